// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state bits are JK flip-flops, with the per-bit J/K drive exposed.
// Define JK_MOD_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] j_bus,
  output logic [WIDTH-1:0] k_bus,
  output logic             tc
);

`ifdef JK_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;
  logic             at_max;
  logic             at_zero;
  logic             out_of_range;

  always_comb begin
    out_of_range = ({1'b0, q} >= MODW);
    at_max       = (q == MAX);
    at_zero      = (q == '0);
    load_val     = ({1'b0, d} >= MODW) ? MAX : d;
    nxt          = q;
    if (load) begin
      nxt = load_val;
    end else if (en) begin
      // An out-of-range state re-enters the count range at the far end of the count direction.
      if (up) begin
        if (out_of_range)  nxt = '0;
        else if (at_max)   nxt = SAT ? MAX : '0;
        else               nxt = q + WIDTH'(1);
      end else begin
        if (out_of_range)  nxt = MAX;
        else if (at_zero)  nxt = SAT ? '0 : MAX;
        else               nxt = q - WIDTH'(1);
      end
    end
  end

  // Load uses set/reset drive; counting and holding use toggle drive, so a hold is J=K=0.
  always_comb begin
    if (rst) begin
      j_bus = '0;
      k_bus = '1;
    end else if (load) begin
      j_bus = nxt;
      k_bus = ~nxt;
    end else begin
      j_bus = q ^ nxt;
      k_bus = q ^ nxt;
    end
  end

  assign tc    = ~rst & en & ~load & (up ? at_max : at_zero);
  assign q_bar = ~q;

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= (j_bus & ~q) | (~k_bus & q);
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter. Each state bit is an edge-triggered JK flip-flop.
- The next-state logic generates per-bit J/K drive and exposes it, so the drive can be checked against the JK characteristic equation Q+ = J·~Q | ~K·Q.
- Sits directly downstream of the JK latch/flip-flop cells: it consumes their J/K/Q behaviour to build a counting stage for the counters and sequencers that follow.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count (JK flip-flop Q outputs).
- q_bar  output  WIDTH  bitwise complement of q.
- j_bus  output  WIDTH  J drive applied to each bit this cycle (combinational).
- k_bus  output  WIDTH  K drive applied to each bit this cycle (combinational).
- tc  output  1  terminal count (combinational).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: when rst=1 at an edge, q=0 and q_bar=all ones. rst=1 holds the counter at zero regardless of en/load. Reset asserted mid-count takes effect at the next edge. No partial state survives.
- Priority: rst > load > en. When en=0 and load=0, the counter holds.
- Next value (nxt):
  - load=1: nxt = d. If d >= MODULUS, nxt = MODULUS-1 (clamp).
  - en=1, up=1: nxt = q+1, except q==MODULUS-1 gives 0 (wrap).
  - en=1, up=0: nxt = q-1, except q==0 gives MODULUS-1 (wrap).
  - Otherwise: nxt = q.
- J/K generation:
  - load cycle: j_bus = nxt, k_bus = ~nxt (set/reset form).
  - Count or hold cycle: j_bus = k_bus = q ^ nxt (toggle form). Hold therefore gives J=K=0 on every bit.
  - rst=1: j_bus = 0, k_bus = all ones.
- State update: each bit updates strictly by Q+ = J·~Q | ~K·Q from j_bus/k_bus. No direct assignment of nxt to q.
- tc: tc = en & ~load & (up ? q==MODULUS-1 : q==0). tc is 0 during rst.
- Latency: one cycle from en/load to the q change. tc, j_bus and k_bus reflect the current inputs and q in the same cycle.
- Direction: changing up mid-count takes effect the same cycle. No extra pipeline.
- Out-of-range state: if q >= MODULUS (only possible when MODULUS < 2**WIDTH, via X/fault), up-count goes to 0 and down-count goes to MODULUS-1.
- Simultaneous load and en: load wins. tc=0 that cycle.

Optional Feature:
- Macro: JK_MOD_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - j_bus = k_bus = 0 in that cycle.
  - tc still asserts at the boundary.
- Undefined: wrap-around behaviour exactly as described above.

Test Plan:
- rst=1 for 2 edges with en=1, up=1 -> q=0, q_bar=4'b1111, tc=0, j_bus=0, k_bus=4'b1111.
- rst=0, en=1, up=1 for 12 edges from 0 -> q sequence 1..9,0,1,2. tc=1 exactly while q=9. On the 7->8 edge, j_bus = k_bus = 4'b1111.
- load=1, d=4'd12 -> q=9 next edge (clamp), j_bus=4'b1001, k_bus=4'b0110. Then en=1, up=0 for 11 edges -> 8..0,9,8, with tc=1 while q=0.
- Hold: q=5, en=0, load=0 for 3 edges -> q stays 5, j_bus = k_bus = 0. Then load=1 with en=1, d=3 -> q=3, tc=0.
- Reset mid-count: q=6, en=1, up=1, rst=1 at one edge -> q=0 next cycle, counting resumes 1,2 after rst drops.
- With JK_MOD_COUNTER_SAT_EN: from q=9, up, 3 edges -> q stays 9, tc=1. From q=0, down, 2 edges -> q stays 0.
